// File: rtl/poly_pkg.sv
// Shared constants, types and FSM encoding for the NTRU-HRSS polynomial
// add sequencer (q = 2^13).
package poly_pkg;
  localparam int NUM_BIT = 13;
  localparam int N_COEF  = 701;
  localparam int ADDR_W  = 10;

  typedef logic [NUM_BIT-1:0] coef_t;
  typedef logic [ADDR_W-1:0]  addr_t;

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} seq_state_t;

  localparam addr_t LAST_ADDR = addr_t'(N_COEF - 1);
endpackage

// File: rtl/add_2i13_o13.sv
// Combinational 13-bit Kogge-Stone prefix adder; carry-out is discarded so
// the result wraps mod 2^13.
module add_2i13_o13 (
  input  logic [12:0] i_a,
  input  logic [12:0] i_b,
  output logic [12:0] o_s
);
  localparam int W    = 13;
  localparam int LVLS = 4;

  logic [W-1:0] w_p0, w_g, w_p, w_gn, w_pn;

  always_comb begin
    w_p0 = i_a ^ i_b;
    w_g  = i_a & i_b;
    w_p  = w_p0;
    w_gn = '0;
    w_pn = '0;
    // each level doubles the span of the group generate/propagate terms
    for (int l = 0; l < LVLS; l++) begin
      w_gn = w_g;
      w_pn = w_p;
      for (int i = 0; i < W; i++) begin
        if (i >= (1 << l)) begin
          w_gn[i] = w_g[i] | (w_p[i] & w_g[i-(1<<l)]);
          w_pn[i] = w_p[i] & w_p[i-(1<<l)];
        end
      end
      w_g = w_gn;
      w_p = w_pn;
    end
    o_s = w_p0 ^ {w_g[W-2:0], 1'b0};
  end
endmodule

// File: rtl/poly_add_seq.sv
// Streams A/B coefficient reads through one prefix adder into a destination
// RAM. POLY_ADD_SUB_EN adds a 'sub' input selecting (A - B) mod 2^13.
module poly_add_seq
  import poly_pkg::*;
(
  input  logic  clk,
  input  logic  rst,
  input  logic  start,
`ifdef POLY_ADD_SUB_EN
  input  logic  sub,
`endif
  output logic  busy,
  output logic  done,
  output logic  rd_en,
  output addr_t rd_addr,
  input  coef_t a_rdata,
  input  coef_t b_rdata,
  output logic  wr_en,
  output addr_t wr_addr,
  output coef_t wr_data
);
  localparam int STAGES = 2;

  seq_state_t r_state, w_nxt;
  addr_t      r_rd_addr;
  logic       r_drain;
  logic [STAGES-1:0] r_vld_pipe;
  addr_t [STAGES-1:0] r_addr_pipe;
  coef_t      r_sum;
  coef_t      w_op_a, w_add, w_res;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_nxt;
  end

  always_comb begin
    w_nxt = r_state;
    case (r_state)
      IDLE:  if (start) w_nxt = RUN;
      RUN:   if (r_rd_addr == LAST_ADDR) w_nxt = DRAIN;
      DRAIN: if (r_drain) w_nxt = DONE;
      DONE:  w_nxt = IDLE;
      default: w_nxt = IDLE;
    endcase
  end

  // r_drain counts the two cycles the result pipeline needs to empty
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rd_addr <= '0;
      r_drain   <= 1'b0;
    end else begin
      case (r_state)
        IDLE: if (start) r_rd_addr <= '0;
        RUN: begin
          r_drain <= 1'b0;
          if (r_rd_addr != LAST_ADDR) r_rd_addr <= r_rd_addr + addr_t'(1);
        end
        DRAIN: r_drain <= ~r_drain;
        default: ;
      endcase
    end
  end

  assign rd_en   = (r_state == RUN);
  assign rd_addr = r_rd_addr;
  assign busy    = (r_state != IDLE);
  assign done    = (r_state == DONE);

`ifdef POLY_ADD_SUB_EN
  logic r_sub;
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                           r_sub <= 1'b0;
    else if (r_state == IDLE && start) r_sub <= sub;
  end
  // a - b == ~(~a + b): reuse the single adder with inverted operand/result
  assign w_op_a = r_sub ? ~a_rdata : a_rdata;
  assign w_res  = r_sub ? ~w_add   : w_add;
`else
  assign w_op_a = a_rdata;
  assign w_res  = w_add;
`endif

  add_2i13_o13 u_add (
    .i_a (w_op_a),
    .i_b (b_rdata),
    .o_s (w_add)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_vld_pipe  <= '0;
      r_addr_pipe <= '0;
      r_sum       <= '0;
    end else begin
      r_vld_pipe  <= {r_vld_pipe[0], rd_en};
      r_addr_pipe <= {r_addr_pipe[0], r_rd_addr};
      r_sum       <= w_res;
    end
  end

  assign wr_en   = r_vld_pipe[STAGES-1];
  assign wr_addr = r_addr_pipe[STAGES-1];
  assign wr_data = wr_en ? r_sum : '0;
endmodule
